// File: rtl/mix_w_transpose_if.sv
// Bus between the mix-weight transpose writer and its surroundings:
// run/valid handshake, W RAM read port and WT RAM write port.
interface mix_w_transpose_if #(
    parameter int DATA_N     = 6,
    parameter int N_LEN_W    = 18,
    parameter int ADDR_WIDTH = 9
);
    logic                        run;
    logic                        valid;
    logic [ADDR_WIDTH-1:0]       raddr;
    logic [DATA_N*N_LEN_W-1:0]   rdata;
    logic                        load;
    logic [ADDR_WIDTH-1:0]       waddr;
    logic [DATA_N*N_LEN_W-1:0]   wdata;

    // Transpose engine side
    modport master (
        input  run, rdata,
        output valid, raddr, load, waddr, wdata
    );

    // Controller / RAM side
    modport slave (
        output run, rdata,
        input  valid, raddr, load, waddr, wdata
    );
endinterface

// File: rtl/mix_w_transpose.sv
// Transposes the three HID_DIM x HID_DIM mix weight matrices from the W RAM
// into the WT RAM, one DATA_N x DATA_N tile at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for run; all outputs at reset values
// S_READ  | cnt 0..DATA_N-1 issue tile row reads, cnt 1..DATA_N capture rows
// S_WRITE | cnt 0..DATA_N-1 write one transposed tile column per cycle
// S_DONE  | all tiles written; valid held until run drops
//
// All outputs are flops loaded from the next-state decode, so run and rdata
// never reach an output combinationally.
module mix_w_transpose #(
    parameter int HID_DIM    = 24,
    parameter int DATA_N     = 6,
    parameter int N_LEN_W    = 18,
    parameter int ADDR_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    mix_w_transpose_if.master  bus
);
    localparam int LPR   = HID_DIM / DATA_N;
    localparam int DW    = DATA_N * N_LEN_W;
    localparam int CNT_W = $clog2(DATA_N + 1);
    localparam int T_W   = (LPR > 1) ? $clog2(LPR) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_m, w_m_nxt;
    logic [T_W-1:0]    r_rb, w_rb_nxt;
    logic [T_W-1:0]    r_cb, w_cb_nxt;
    logic [DW-1:0]     r_buf [DATA_N];
    logic [DW-1:0]     w_buf_nxt [DATA_N];
    logic              w_last_tile;

    logic                   r_valid, r_load;
    logic [ADDR_WIDTH-1:0]  r_raddr, r_waddr, w_raddr_nxt, w_waddr_nxt;
    logic [DW-1:0]          r_wdata, w_wdata_nxt;

    function automatic logic [ADDR_WIDTH-1:0] f_line(input int m, input int row, input int col);
        return ADDR_WIDTH'(m * HID_DIM * LPR + row * LPR + col);
    endfunction

    assign w_last_tile = (r_m == 2'd2) && (r_rb == T_W'(LPR - 1)) && (r_cb == T_W'(LPR - 1));

    // Next-state and tile walk: m outermost, rb, then cb innermost
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_m_nxt     = r_m;
        w_rb_nxt    = r_rb;
        w_cb_nxt    = r_cb;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = '0;
                    w_m_nxt     = '0;
                    w_rb_nxt    = '0;
                    w_cb_nxt    = '0;
                end
            end
            S_READ, S_WRITE: begin
                if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_m_nxt     = '0;
                    w_rb_nxt    = '0;
                    w_cb_nxt    = '0;
                end else if (r_state == S_READ && r_cnt == CNT_W'(DATA_N)) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = '0;
                end else if (r_state == S_WRITE && r_cnt == CNT_W'(DATA_N - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_last_tile) begin
                        w_state_nxt = S_DONE;
                        w_m_nxt     = '0;
                        w_rb_nxt    = '0;
                        w_cb_nxt    = '0;
                    end else begin
                        w_state_nxt = S_READ;
                        if (r_cb == T_W'(LPR - 1)) begin
                            w_cb_nxt = '0;
                            if (r_rb == T_W'(LPR - 1)) begin
                                w_rb_nxt = '0;
                                w_m_nxt  = r_m + 2'd1;
                            end else begin
                                w_rb_nxt = r_rb + T_W'(1);
                            end
                        end else begin
                            w_cb_nxt = r_cb + T_W'(1);
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!bus.run) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tile buffer: the row read at READ cnt-1 arrives while cnt is current
    always_comb begin
        for (int r = 0; r < DATA_N; r++) begin
            w_buf_nxt[r] = r_buf[r];
            if (r_state == S_READ && int'(r_cnt) == r + 1) w_buf_nxt[r] = bus.rdata;
        end
    end

    // Output decode of the state about to be entered
    always_comb begin
        w_raddr_nxt = '0;
        w_waddr_nxt = '0;
        w_wdata_nxt = '0;
        if (w_state_nxt == S_READ && w_cnt_nxt < CNT_W'(DATA_N))
            w_raddr_nxt = f_line(int'(w_m_nxt), int'(w_rb_nxt) * DATA_N + int'(w_cnt_nxt), int'(w_cb_nxt));
        if (w_state_nxt == S_WRITE) begin
            w_waddr_nxt = f_line(int'(w_m_nxt), int'(w_cb_nxt) * DATA_N + int'(w_cnt_nxt), int'(w_rb_nxt));
            for (int r = 0; r < DATA_N; r++)
                w_wdata_nxt[r * N_LEN_W +: N_LEN_W] = w_buf_nxt[r][int'(w_cnt_nxt) * N_LEN_W +: N_LEN_W];
        end
    end

    // State, counters, tile buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_rb    <= '0;
            r_cb    <= '0;
            for (int r = 0; r < DATA_N; r++) r_buf[r] <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_m     <= w_m_nxt;
            r_rb    <= w_rb_nxt;
            r_cb    <= w_cb_nxt;
            for (int r = 0; r < DATA_N; r++) r_buf[r] <= w_buf_nxt[r];
            r_valid <= (w_state_nxt == S_DONE);
            r_load  <= (w_state_nxt == S_WRITE);
            r_raddr <= w_raddr_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign bus.valid = r_valid;
    assign bus.load  = r_load;
    assign bus.raddr = r_raddr;
    assign bus.waddr = r_waddr;
    assign bus.wdata = r_wdata;
endmodule

// File: tb/tb_mix_w_transpose.sv
// Bench for mix_w_transpose: W/WT RAM models, a tile-schedule reference model
// derived from the matrix indexing, and directed plus randomized runs.
module tb_mix_w_transpose;
    localparam int HID      = 24;
    localparam int DN       = 6;
    localparam int NW       = 18;
    localparam int AW       = 9;
    localparam int LPR      = HID / DN;
    localparam int DW       = DN * NW;
    localparam int NLINES   = 3 * HID * LPR;
    localparam int TILE_CYC = 2 * DN + 1;
    localparam int TOTAL    = 3 * LPR * LPR * TILE_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mix_w_transpose_if #(.DATA_N(DN), .N_LEN_W(NW), .ADDR_WIDTH(AW)) bus ();

    mix_w_transpose #(.HID_DIM(HID), .DATA_N(DN), .N_LEN_W(NW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [NW-1:0] wm [3][HID][HID];
    logic [DW-1:0] wt_mem [NLINES];

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;

    // reference model: cycle index within an active run, or done flag
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    int m_k    = 0;

    function automatic logic [DW-1:0] w_line(input logic [AW-1:0] a);
        int ai, m, i, cb;
        logic [DW-1:0] l;
        l  = '0;
        ai = int'(a);
        if (ai < NLINES) begin
            m  = ai / (HID * LPR);
            i  = (ai / LPR) % HID;
            cb = ai % LPR;
            for (int r = 0; r < DN; r++) l[r * NW +: NW] = wm[m][i][cb * DN + r];
        end
        return l;
    endfunction

    // W RAM read port, one cycle latency
    always @(posedge clk) bus.rdata <= w_line(bus.raddr);

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic compare();
        logic          ev, el;
        logic [AW-1:0] era, ewa;
        logic [DW-1:0] ewd;
        int t, p, mm, rb, cb, c;
        ev = m_done; el = 1'b0; era = '0; ewa = '0; ewd = '0;
        if (m_act) begin
            t  = m_k / TILE_CYC;
            p  = m_k % TILE_CYC;
            mm = t / (LPR * LPR);
            rb = (t / LPR) % LPR;
            cb = t % LPR;
            if (p < DN) begin
                era = AW'(mm * HID * LPR + (rb * DN + p) * LPR + cb);
            end else if (p > DN) begin
                c   = p - DN - 1;
                el  = 1'b1;
                ewa = AW'(mm * HID * LPR + (cb * DN + c) * LPR + rb);
                for (int r = 0; r < DN; r++) ewd[r * NW +: NW] = wm[mm][rb * DN + r][cb * DN + c];
            end
        end
        chk("ctrl{valid,load,raddr,waddr}", DW'({bus.valid, bus.load, bus.raddr, bus.waddr}),
            DW'({ev, el, era, ewa}));
        chk("wdata", bus.wdata, ewd);
    endtask

    // One clock: commit WT write seen this cycle, advance model, check outputs
    task automatic cycle();
        logic          s_load;
        logic [AW-1:0] s_waddr;
        logic [DW-1:0] s_wdata;
        s_load  = bus.load;
        s_waddr = bus.waddr;
        s_wdata = bus.wdata;
        @(posedge clk);
        if (s_load) begin
            n_loads++;
            if (int'(s_waddr) < NLINES) wt_mem[s_waddr] = s_wdata;
        end
        if (!rst_n) begin
            m_act = 1'b0; m_done = 1'b0; m_k = 0;
        end else if (m_done) begin
            if (!bus.run) m_done = 1'b0;
        end else if (m_act) begin
            if (!bus.run) begin
                m_act = 1'b0; m_k = 0;
            end else if (m_k == TOTAL - 1) begin
                m_act = 1'b0; m_done = 1'b1; m_k = 0;
            end else begin
                m_k++;
            end
        end else if (bus.run) begin
            m_act = 1'b1; m_k = 0;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic fill_pattern();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < HID; i++)
                for (int j = 0; j < HID; j++) wm[m][i][j] = NW'(m * HID * HID + i * HID + j);
    endtask

    task automatic fill_random();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < HID; i++)
                for (int j = 0; j < HID; j++) wm[m][i][j] = NW'($urandom);
    endtask

    task automatic clear_wt();
        for (int a = 0; a < NLINES; a++) wt_mem[a] = '1;
    endtask

    task automatic check_wt();
        int m, j, ib;
        logic [DW-1:0] e;
        for (int a = 0; a < NLINES; a++) begin
            m  = a / (HID * LPR);
            j  = (a / LPR) % HID;
            ib = a % LPR;
            for (int r = 0; r < DN; r++) e[r * NW +: NW] = wm[m][ib * DN + r][j];
            chk($sformatf("wt_line[%0d]", a), wt_mem[a], e);
        end
    endtask

    task automatic wait_valid();
        for (int n = 0; n < TOTAL + 50 && !bus.valid; n++) cycle();
        chk("valid_within_budget", DW'(bus.valid), DW'(1));
    endtask

    initial begin
        logic [DW-1:0] e;
        int loads_before;
        bus.run = 1'b0;
        fill_pattern();
        clear_wt();
        @(negedge clk);
        cycle();
        chk("reset_outputs", DW'({bus.valid, bus.load, bus.raddr, bus.waddr}) | bus.wdata, '0);
        rst_n = 1'b1;
        cycle();

        // full run on the index pattern, with tile 0 and last tile pinned
        bus.run = 1'b1;
        cycle();
        chk("tile0_raddr0", DW'(bus.raddr), DW'(0));
        for (int p = 1; p < DN; p++) begin
            cycle();
            chk($sformatf("tile0_raddr%0d", p), DW'(bus.raddr), DW'(4 * p));
        end
        cycle();
        cycle();
        chk("tile0_first_write", DW'({bus.load, bus.waddr}), DW'({1'b1, 9'd0}));
        for (int r = 0; r < DN; r++) e[r * NW +: NW] = NW'(24 * r);
        chk("tile0_first_wdata", bus.wdata, e);
        repeat (TOTAL - 1 - 7) cycle();
        chk("last_write", DW'({bus.load, bus.waddr}), DW'({1'b1, 9'd287}));
        for (int r = 0; r < DN; r++) e[r * NW +: NW] = NW'(1607 + 24 * r);
        chk("last_wdata", bus.wdata, e);
        cycle();
        chk("done_valid_noload", DW'({bus.valid, bus.load}), DW'(2'b10));
        repeat (50) cycle();
        chk("done_hold", DW'({bus.valid, bus.load}), DW'(2'b10));
        check_wt();
        bus.run = 1'b0;
        cycle();
        chk("valid_drop", DW'(bus.valid), DW'(0));
        cycle();

        // abort at cycle 100, then rerun on random data
        fill_random();
        clear_wt();
        bus.run = 1'b1;
        cycle();
        repeat (99) cycle();
        bus.run = 1'b0;
        cycle();
        chk("abort_idle", DW'({bus.valid, bus.load}), DW'(0));
        repeat (20) cycle();
        bus.run = 1'b1;
        for (int n = 0; n < 20 && !bus.load; n++) cycle();
        chk("rerun_first_waddr", DW'({bus.load, bus.waddr}), DW'({1'b1, 9'd0}));
        wait_valid();
        check_wt();
        bus.run = 1'b0;
        cycle();

        // asynchronous reset during a write cycle
        fill_random();
        bus.run = 1'b1;
        cycle();
        repeat (8) cycle();
        chk("in_write_before_reset", DW'(bus.load), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", DW'({bus.valid, bus.load, bus.raddr, bus.waddr}) | bus.wdata, '0);
        bus.run = 1'b0;
        m_act = 1'b0; m_done = 1'b0; m_k = 0;
        @(negedge clk);
        repeat (3) cycle();
        rst_n = 1'b1;
        loads_before = n_loads;
        repeat (10) cycle();
        chk("no_load_after_reset", DW'(n_loads), DW'(loads_before));

        // final randomized full run
        fill_random();
        clear_wt();
        bus.run = 1'b1;
        wait_valid();
        check_wt();
        bus.run = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
